// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch-to-decode instruction queue.
//   fetch_entry_t   one queue entry {instr, pc}
//   FETCH_WIDTH_C   default instructions per fetch packet
//   DECODE_WIDTH_C  default instructions offered to decode per cycle
package fetch_pkg;
  localparam int XLEN_C         = 32;
  localparam int FETCH_WIDTH_C  = 5;
  localparam int DECODE_WIDTH_C = 3;

  typedef struct packed {
    logic [XLEN_C-1:0] instr;
    logic [XLEN_C-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue_ram.sv
// fetch_queue_ram: DEPTH-entry storage for the instruction queue.
//   clk     write clock
//   wr_ptr  base index of the write burst; port j writes wr_ptr+j (mod DEPTH)
//   wr_num  number of write ports active this cycle (ports 0..wr_num-1)
//   wdata   per-port write data
//   rd_ptr  base index of the read window; port i reads rd_ptr+i (mod DEPTH)
//   rdata   per-port asynchronous read data
// Contents are never cleared; validity is tracked by the owner's pointers.
module fetch_queue_ram
  import fetch_pkg::*;
#(
  parameter int  DEPTH        = 16,
  parameter int  FETCH_WIDTH  = FETCH_WIDTH_C,
  parameter int  DECODE_WIDTH = DECODE_WIDTH_C,
  parameter type entry_t      = fetch_entry_t,
  parameter int  AW           = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic [AW-1:0]              wr_ptr,
  input  logic [AW:0]                wr_num,
  input  entry_t [FETCH_WIDTH-1:0]   wdata,
  input  logic [AW-1:0]              rd_ptr,
  output entry_t [DECODE_WIDTH-1:0]  rdata
);
  entry_t mem [DEPTH];

  // Addresses within one burst are distinct because FETCH_WIDTH <= DEPTH;
  // the AW-bit add wraps naturally at DEPTH.
  always_ff @(posedge clk) begin
    for (int j = 0; j < FETCH_WIDTH; j++)
      if (j < int'(wr_num)) mem[wr_ptr + AW'(j)] <= wdata[j];
  end

  for (genvar i = 0; i < DECODE_WIDTH; i++) begin : g_rd
    assign rdata[i] = mem[rd_ptr + AW'(i)];
  end
endmodule

// File: rtl/fetch_inst_queue.sv
// fetch_inst_queue: decoupling buffer between the fetch PC controller and decode.
//   clk, reset    clock; synchronous active-high reset
//   fetch_valid   fetch packet present
//   fetch_count   valid slots in packet (contiguous from slot 0, clamped to FETCH_WIDTH)
//   fetch_instr   packet instructions, slot 0 in the LSBs
//   fetch_pc      packet PCs
//   flush         misprediction: drop all entries, ignore this cycle's write/pop
//   buble         stall to the PC controller: free entries < FETCH_WIDTH
//   dec_valid     thermometer of offered entries, oldest in lane 0
//   dec_instr     offered instructions
//   dec_pc        offered PCs
//   dec_accept    entries consumed by decode (clamped to the offered count)
//   occupancy     current entry count
// Optional macro FETCH_QUEUE_BYPASS_EN: when the queue is empty, a written packet
// is offered to decode in the same cycle and only the unconsumed tail is stored.
module fetch_inst_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int FETCH_WIDTH  = FETCH_WIDTH_C,
  parameter int DECODE_WIDTH = DECODE_WIDTH_C,
  parameter int XLEN         = XLEN_C
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 fetch_valid,
  input  logic [2:0]                           fetch_count,
  input  logic [FETCH_WIDTH-1:0][XLEN-1:0]     fetch_instr,
  input  logic [FETCH_WIDTH-1:0][XLEN-1:0]     fetch_pc,
  input  logic                                 flush,
  output logic                                 buble,
  output logic [DECODE_WIDTH-1:0]              dec_valid,
  output logic [DECODE_WIDTH-1:0][XLEN-1:0]    dec_instr,
  output logic [DECODE_WIDTH-1:0][XLEN-1:0]    dec_pc,
  input  logic [1:0]                           dec_accept,
  output logic [$clog2(DEPTH):0]               occupancy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } entry_t;

  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;

  logic [2:0]    fetch_n;
  logic          wr_en, byp;
  logic [CW-1:0] avail, pop, pop_ram, n_store, shift;
  entry_t [FETCH_WIDTH-1:0]  wdata;
  entry_t [DECODE_WIDTH-1:0] rdata;

  assign buble     = (CW'(DEPTH) - count) < CW'(FETCH_WIDTH);
  assign occupancy = count;
  assign fetch_n   = (fetch_count > 3'(FETCH_WIDTH)) ? 3'(FETCH_WIDTH) : fetch_count;
  assign wr_en     = fetch_valid && !buble && !flush;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp = wr_en && (count == '0) && (fetch_n != 3'd0);
`else
  assign byp = 1'b0;
`endif

  always_comb begin
    if (flush)    avail = '0;
    else if (byp) avail = (CW'(fetch_n) < CW'(DECODE_WIDTH)) ? CW'(fetch_n) : CW'(DECODE_WIDTH);
    else          avail = (count < CW'(DECODE_WIDTH)) ? count : CW'(DECODE_WIDTH);
    pop = (CW'(dec_accept) < avail) ? CW'(dec_accept) : avail;

    // Bypassed slots consumed this cycle are never stored; the remainder is
    // shifted down so that it lands at wr_ptr onward.
    shift   = byp ? pop : '0;
    n_store = wr_en ? (CW'(fetch_n) - shift) : '0;
    pop_ram = byp ? '0 : pop;

    for (int j = 0; j < FETCH_WIDTH; j++) begin
      wdata[j] = '0;
      if (j + int'(shift) < FETCH_WIDTH) begin
        wdata[j].instr = fetch_instr[j + int'(shift)];
        wdata[j].pc    = fetch_pc[j + int'(shift)];
      end
    end

    for (int i = 0; i < DECODE_WIDTH; i++) begin
      dec_valid[i] = CW'(i) < avail;
      dec_instr[i] = rdata[i].instr;
      dec_pc[i]    = rdata[i].pc;
`ifdef FETCH_QUEUE_BYPASS_EN
      if (byp) begin
        dec_instr[i] = fetch_instr[i];
        dec_pc[i]    = fetch_pc[i];
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + AW'(pop_ram);
      wr_ptr <= wr_ptr + AW'(n_store);
      count  <= count + n_store - pop_ram;
    end
  end

  fetch_queue_ram #(
    .DEPTH        (DEPTH),
    .FETCH_WIDTH  (FETCH_WIDTH),
    .DECODE_WIDTH (DECODE_WIDTH),
    .entry_t      (entry_t)
  ) u_ram (
    .clk    (clk),
    .wr_ptr (wr_ptr),
    .wr_num (n_store),
    .wdata  (wdata),
    .rd_ptr (rd_ptr),
    .rdata  (rdata)
  );
endmodule

// File: tb/tb_fetch_inst_queue.sv
// Self-checking bench for fetch_inst_queue: directed scenarios plus random
// traffic, all compared against a PC-queue reference model.
module tb_fetch_inst_queue;
  localparam int DEPTH = 16, FW = 5, DW = 3, XLEN = 32;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, fetch_valid, flush, buble;
  logic [2:0] fetch_count;
  logic [1:0] dec_accept;
  logic [FW-1:0][XLEN-1:0] fetch_instr, fetch_pc;
  logic [DW-1:0] dec_valid;
  logic [DW-1:0][XLEN-1:0] dec_instr, dec_pc;
  logic [4:0] occupancy;

  always #5 clk = ~clk;

  fetch_inst_queue #(.DEPTH(DEPTH), .FETCH_WIDTH(FW), .DECODE_WIDTH(DW), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .fetch_valid(fetch_valid), .fetch_count(fetch_count),
    .fetch_instr(fetch_instr), .fetch_pc(fetch_pc), .flush(flush), .buble(buble),
    .dec_valid(dec_valid), .dec_instr(dec_instr), .dec_pc(dec_pc),
    .dec_accept(dec_accept), .occupancy(occupancy));

  int n_chk = 0, n_fail = 0;
  logic [31:0] q[$];
  logic [31:0] next_pc = 32'h8000_0000;
  logic [DW-1:0] s_valid, e_valid;
  logic [DW-1:0][31:0] s_pc, e_pc, s_instr, e_instr;
  logic [4:0] s_occ, e_occ;
  logic s_bub, e_bub;
  int g_pop;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {pc[15:0], pc[31:16]} ^ 32'hDEAD_BEEF;
  endfunction

  // One clock: drive inputs, sample at the falling edge, then advance the model.
  task automatic step(input bit fv, input int fc, input int acc, input bit fl, input bit rs);
    int n, off;
    bit wr, byp;
    reset = rs; fetch_valid = fv; fetch_count = 3'(fc); dec_accept = 2'(acc); flush = fl;
    for (int i = 0; i < FW; i++) begin
      fetch_pc[i]    = next_pc + 32'(4 * i);
      fetch_instr[i] = instr_of(fetch_pc[i]);
    end
    @(negedge clk);
    n     = (fc > FW) ? FW : fc;
    e_occ = 5'(q.size());
    e_bub = (DEPTH - q.size()) < FW;
    wr    = fv && !e_bub && !fl;
    byp   = BYP && wr && (q.size() == 0) && (n > 0);
    off   = fl ? 0 : byp ? ((n < DW) ? n : DW) : ((q.size() < DW) ? q.size() : DW);
    g_pop = (acc < off) ? acc : off;
    e_valid = '0; e_pc = '0; e_instr = '0; s_pc = '0; s_instr = '0;
    for (int i = 0; i < DW; i++) begin
      if (i < off) begin
        e_valid[i] = 1'b1;
        e_pc[i]    = byp ? next_pc + 32'(4 * i) : q[i];
        e_instr[i] = instr_of(e_pc[i]);
        s_pc[i]    = dec_pc[i];
        s_instr[i] = dec_instr[i];
      end
    end
    s_valid = dec_valid; s_occ = occupancy; s_bub = buble;
    @(posedge clk);
    if (rs || fl) q.delete();
    else if (byp) begin
      for (int i = g_pop; i < n; i++) q.push_back(next_pc + 32'(4 * i));
    end else begin
      repeat (g_pop) void'(q.pop_front());
      if (wr) for (int i = 0; i < n; i++) q.push_back(next_pc + 32'(4 * i));
    end
    if (wr && !rs) next_pc += 32'(4 * n);
    #1;
  endtask

  task automatic test_reset;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    n_chk++; if (s_valid !== 3'b000) begin n_fail++; $display("FAIL reset_valid got %b exp 000", s_valid); end
    n_chk++; if (s_bub !== 1'b0) begin n_fail++; $display("FAIL reset_buble got %b exp 0", s_bub); end
    n_chk++; if (s_occ !== 5'd0) begin n_fail++; $display("FAIL reset_occ got %0d exp 0", s_occ); end
  endtask

  task automatic test_fill;
    int exp_occ[4] = '{0, 5, 10, 15};
    for (int k = 0; k < 4; k++) begin
      step(1, 5, 0, 0, 0);  // 4th packet must be dropped by the stall
      n_chk++;
      if (s_valid !== e_valid || s_pc !== e_pc || s_instr !== e_instr || s_occ !== e_occ || s_bub !== e_bub) begin
        n_fail++; $display("FAIL fill_model valid %b/%b pc0 %h/%h occ %0d/%0d bub %b/%b", s_valid, e_valid, s_pc[0], e_pc[0], s_occ, e_occ, s_bub, e_bub);
      end
      n_chk++; if (s_occ !== 5'(exp_occ[k])) begin n_fail++; $display("FAIL fill_occ%0d got %0d exp %0d", k, s_occ, exp_occ[k]); end
    end
    n_chk++; if (s_bub !== 1'b1) begin n_fail++; $display("FAIL fill_buble got %b exp 1", s_bub); end
  endtask

  task automatic test_drain;
    logic [31:0] exp = 32'h8000_0000;
    for (int c = 0; c < 7; c++) begin
      step(0, 0, 3, 0, 0);
      n_chk++;
      if (s_valid !== e_valid || s_pc !== e_pc || s_instr !== e_instr || s_occ !== e_occ || s_bub !== e_bub) begin
        n_fail++; $display("FAIL drain_model valid %b/%b pc0 %h/%h occ %0d/%0d bub %b/%b", s_valid, e_valid, s_pc[0], e_pc[0], s_occ, e_occ, s_bub, e_bub);
      end
      n_chk++; if (s_bub !== (s_occ > 5'd11)) begin n_fail++; $display("FAIL drain_buble got %b at occ %0d", s_bub, s_occ); end
      for (int i = 0; i < g_pop; i++) begin
        n_chk++; if (s_pc[i] !== exp) begin n_fail++; $display("FAIL drain_order got %h exp %h", s_pc[i], exp); end
        exp += 32'd4;
      end
    end
    n_chk++; if (s_occ !== 5'd0) begin n_fail++; $display("FAIL drain_empty got %0d exp 0", s_occ); end
  endtask

  task automatic test_simultaneous;
    logic [31:0] b = next_pc;
    step(1, 5, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 5, 3, 0, 0);
    n_chk++; if (s_occ !== 5'd6) begin n_fail++; $display("FAIL simul_occ6 got %0d exp 6", s_occ); end
    step(0, 0, 0, 0, 0);
    n_chk++;
    if (s_valid !== e_valid || s_pc !== e_pc || s_instr !== e_instr || s_occ !== e_occ || s_bub !== e_bub) begin
      n_fail++; $display("FAIL simul_model valid %b/%b pc0 %h/%h occ %0d/%0d", s_valid, e_valid, s_pc[0], e_pc[0], s_occ, e_occ);
    end
    n_chk++; if (s_occ !== 5'd8) begin n_fail++; $display("FAIL simul_occ8 got %0d exp 8", s_occ); end
    n_chk++; if (s_pc[0] !== b + 32'd12) begin n_fail++; $display("FAIL simul_oldest got %h exp %h", s_pc[0], b + 32'd12); end
  endtask

  task automatic test_flush;
    step(0, 0, 0, 1, 0);
    step(1, 5, 0, 0, 0);
    step(1, 4, 0, 0, 0);
    step(1, 5, 1, 1, 0);
    n_chk++; if (s_occ !== 5'd9) begin n_fail++; $display("FAIL flush_pre_occ got %0d exp 9", s_occ); end
    n_chk++; if (s_valid !== 3'b000) begin n_fail++; $display("FAIL flush_valid_n got %b exp 000", s_valid); end
    step(0, 0, 0, 0, 0);
    n_chk++; if (s_valid !== 3'b000) begin n_fail++; $display("FAIL flush_valid_n1 got %b exp 000", s_valid); end
    n_chk++; if (s_occ !== 5'd0) begin n_fail++; $display("FAIL flush_occ got %0d exp 0", s_occ); end
    step(0, 0, 0, 0, 0);
    n_chk++; if (s_occ !== 5'd0) begin n_fail++; $display("FAIL flush_nowrite got %0d exp 0", s_occ); end
  endtask

  task automatic test_bypass;
    logic [31:0] b = next_pc;
    step(1, 2, 2, 0, 0);
`ifdef FETCH_QUEUE_BYPASS_EN
    n_chk++; if (s_valid !== 3'b011) begin n_fail++; $display("FAIL byp_valid got %b exp 011", s_valid); end
    n_chk++; if (s_pc[0] !== b || s_pc[1] !== b + 32'd4) begin n_fail++; $display("FAIL byp_pc got %h %h exp %h %h", s_pc[0], s_pc[1], b, b + 32'd4); end
    step(0, 0, 0, 0, 0);
    n_chk++; if (s_occ !== 5'd0 || s_valid !== 3'b000) begin n_fail++; $display("FAIL byp_after got occ %0d valid %b exp 0 000", s_occ, s_valid); end
`else
    n_chk++; if (s_valid !== 3'b000) begin n_fail++; $display("FAIL nobyp_valid got %b exp 000", s_valid); end
    step(0, 0, 0, 0, 0);
    n_chk++; if (s_occ !== 5'd2 || s_valid !== 3'b011) begin n_fail++; $display("FAIL nobyp_after got occ %0d valid %b exp 2 011", s_occ, s_valid); end
    n_chk++; if (s_pc[0] !== b || s_pc[1] !== b + 32'd4) begin n_fail++; $display("FAIL nobyp_pc got %h %h exp %h %h", s_pc[0], s_pc[1], b, b + 32'd4); end
`endif
    step(0, 0, 0, 1, 0);
  endtask

  task automatic test_wrap;
    logic [31:0] exp = next_pc;
    for (int c = 0; c < 46; c++) begin
      if (c < 40) step(1, 4, 3, 0, 0); else step(0, 0, 3, 0, 0);
      n_chk++;
      if (s_valid !== e_valid || s_pc !== e_pc || s_instr !== e_instr || s_occ !== e_occ || s_bub !== e_bub) begin
        n_fail++; $display("FAIL wrap_model c%0d valid %b/%b pc0 %h/%h occ %0d/%0d", c, s_valid, e_valid, s_pc[0], e_pc[0], s_occ, e_occ);
      end
      for (int i = 0; i < g_pop; i++) begin
        n_chk++; if (s_pc[i] !== exp) begin n_fail++; $display("FAIL wrap_order got %h exp %h", s_pc[i], exp); end
        exp += 32'd4;
      end
    end
  endtask

  task automatic test_random;
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 3),
           $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0);
      n_chk++;
      if (s_valid !== e_valid || s_pc !== e_pc || s_instr !== e_instr || s_occ !== e_occ || s_bub !== e_bub) begin
        n_fail++; $display("FAIL rand_model c%0d valid %b/%b pc0 %h/%h occ %0d/%0d bub %b/%b", c, s_valid, e_valid, s_pc[0], e_pc[0], s_occ, e_occ, s_bub, e_bub);
      end
    end
  endtask

  initial begin
    reset = 1'b1; fetch_valid = 1'b0; fetch_count = '0; dec_accept = '0; flush = 1'b0;
    fetch_pc = '0; fetch_instr = '0;
    @(posedge clk); #1;
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_flush();
    test_bypass();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_inst_queue.md
# fetch_inst_queue

Decoupling instruction buffer between the superscalar fetch PC controller and the decode stage. Each cycle it accepts a packet of up to FETCH_WIDTH instructions with their PCs from instruction memory. It presents up to DECODE_WIDTH of the oldest entries, in program order, to decode. It drives the fetch-side stall (`buble`) and empties completely on a misprediction flush.

## Interface
Parameters:
- DEPTH, 16, entry count; power of two, ≥ 2·FETCH_WIDTH
- FETCH_WIDTH, 5, instructions per fetch packet
- DECODE_WIDTH, 3, instructions offered to decode per cycle
- XLEN, 32, instruction and PC width

Ports:
- Clock and reset (already decided): one clock; reset is synchronous and active-high.
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- fetch_valid  in  1  fetch packet present this cycle
- fetch_count  in  3  number of valid slots in the packet, 0..FETCH_WIDTH; valid slots are contiguous from slot 0
- fetch_instr  in  FETCH_WIDTH×XLEN  packed instructions; slot 0 occupies the LSBs
- fetch_pc  in  FETCH_WIDTH×XLEN  PC of each slot
- flush  in  1  misprediction; empties the queue
- buble  out  1  stall request to the PC controller; high when free entries < FETCH_WIDTH
- dec_valid  out  DECODE_WIDTH  thermometer code: bit i = entry i offered
- dec_instr  out  DECODE_WIDTH×XLEN  oldest-first instructions
- dec_pc  out  DECODE_WIDTH×XLEN  matching PCs
- dec_accept  in  2  number of offered entries decode consumes this cycle, 0..DECODE_WIDTH
- occupancy  out  $clog2(DEPTH)+1  current entry count (debug/perf)

## Operation
- State:
  - rd_ptr and wr_ptr, $clog2(DEPTH) bits each; both wrap modulo DEPTH.
  - count, $clog2(DEPTH)+1 bits.
  - Entry storage is a RAM of {instr, pc}.
- Write:
  - Condition: fetch_valid && !buble && !flush.
  - Slots 0..fetch_count-1 go to wr_ptr..wr_ptr+fetch_count-1 (mod DEPTH).
  - wr_ptr advances by fetch_count.
  - fetch_count = 0 is a legal no-op.
  - fetch_count > FETCH_WIDTH is clamped to FETCH_WIDTH.
- Packets presented while buble=1 are dropped. The PC controller holds the PC in that case, so nothing is lost.
- Read:
  - dec_valid[i] = (i < min(count, DECODE_WIDTH)).
  - dec_*[i] = entry at rd_ptr+i (mod DEPTH).
- Pop:
  - pop = min(dec_accept, popcount(dec_valid)).
  - rd_ptr advances by pop.
  - dec_accept above the offered count is clamped. It is not an error.
- Count update: count_next = count + written − popped. Simultaneous write and pop in the same cycle is required to work.
- buble = (DEPTH − count) < FETCH_WIDTH, combinational from registered count.
- Flush:
  - rd_ptr, wr_ptr and count go to 0.
  - Writes and pops in the flush cycle are discarded.
  - dec_valid is forced to 0 in the flush cycle itself.
  - flush takes priority over everything except reset.
- Reset: same as flush. Reset mid-operation discards all contents. Entry RAM is not cleared.

## Timing
- Reset values: buble=0, dec_valid=0, occupancy=0, dec_instr/dec_pc don't-care (outputs 0 acceptable).
- Latency, write to decode-visible: 1 cycle. An entry written at edge N is offered in cycle N+1.
- Pop is effective at the edge where dec_accept is sampled. The next oldest entries are offered the following cycle.
- buble rises in the cycle after the write that reduces free entries below FETCH_WIDTH. It falls in the cycle after the pop that restores them.
- Flush at cycle N gives: dec_valid=0 in N and N+1; the earliest new entry is offered in N+2 (N+1 with bypass).
- Wrap-around: multi-slot writes and reads straddling index DEPTH−1→0 must preserve order.

## Configuration
- FETCH_QUEUE_BYPASS_EN
  - Defined: when count==0 and a write occurs, fetch slots 0..DECODE_WIDTH−1 are offered combinationally in the same cycle.
  - Entries popped in that cycle are not stored; only the remainder is written.
  - Write-to-decode latency becomes 0 when empty.
- Undefined: no combinational path from fetch_* to dec_*. Latency is always 1 cycle.

## Structure
- Shared package fetch_pkg:
  - typedef fetch_entry_t {logic [XLEN-1:0] instr; logic [XLEN-1:0] pc;}
  - constants FETCH_WIDTH_C=5 and DECODE_WIDTH_C=3
- Sub-module fetch_queue_ram:
  - DEPTH×entry storage
  - FETCH_WIDTH write ports, DECODE_WIDTH asynchronous read ports, per-port mod-DEPTH addressing

## Test plan
- Fill: reset, then 3 packets of count=5 (PCs 0x80000000+4k), dec_accept=0 → occupancy 5, 10, 15 and buble=1 after the third.
- Drain with order: from full (15), dec_accept=3 each cycle → dec_pc sequence 0x80000000, …, 0x80000038 strictly increasing by 4. buble falls when occupancy ≤ 11.
- Wrap: run the read/write pointers past index 15 with count=4 writes and accept=3 → no lost, duplicated or reordered PCs across the 0/15 boundary.
- Simultaneous: occupancy 6, write count=5 with accept=3 → occupancy 8 next cycle; the offered oldest is the 4th previously-queued entry.
- Flush: occupancy 9, assert flush together with fetch_valid count=5 → dec_valid=0 that cycle and the next; occupancy=0; none of the 5 written.
- Bypass (macro defined): empty queue, write count=2, dec_accept=2 → both offered the same cycle; occupancy stays 0. Without the macro: offered 1 cycle later, occupancy=2.
